// File: rtl/dlsc_axi_router_pkg.sv
// Helpers shared by the AXI router channel and its command arbiter.
package dlsc_axi_router_pkg;

  localparam int MAXW = 64;

  function automatic int onehot2bin(input logic [MAXW-1:0] oh);
    int b;
    b = 0;
    for (int i = 0; i < MAXW; i++)
      if (oh[i]) b = b | i;
    return b;
  endfunction

  function automatic logic region_match(input logic [MAXW-1:0] addr,
                                        input logic [MAXW-1:0] base,
                                        input logic [MAXW-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/dlsc_axi_router_cmd_arbiter_if.sv
// Request and command bus of one router channel's command arbiter.
interface dlsc_axi_router_cmd_arbiter_if #(
  parameter int ADDR     = 32,
  parameter int SOURCES  = 1,
  parameter int SOURCESB = 1,
  parameter int SINKS    = 1,
  parameter int SINKSB   = 1
);
  logic [SOURCES-1:0]      in_ready;
  logic [SOURCES-1:0]      in_valid;
  logic [SOURCES*ADDR-1:0] in_addr;
  logic [SOURCES-1:0]      cmd_full_source;
  logic [SINKS-1:0]        cmd_full_sink;
  logic                    cmd_push;
  logic [SOURCES-1:0]      cmd_source_onehot;
  logic [SINKS-1:0]        cmd_sink_onehot;
  logic [SOURCESB-1:0]     cmd_source;
  logic [SINKSB-1:0]       cmd_sink;
  logic                    decerr_push;
  logic [SOURCESB-1:0]     decerr_source;

  modport master (
    input  in_ready, cmd_push, cmd_source_onehot, cmd_sink_onehot,
           cmd_source, cmd_sink, decerr_push, decerr_source,
    output in_valid, in_addr, cmd_full_source, cmd_full_sink
  );

  modport slave (
    output in_ready, cmd_push, cmd_source_onehot, cmd_sink_onehot,
           cmd_source, cmd_sink, decerr_push, decerr_source,
    input  in_valid, in_addr, cmd_full_source, cmd_full_sink
  );
endinterface

// File: rtl/dlsc_axi_router_cmd_rr.sv
// Round-robin arbiter: search starts one past the last granted source.
module dlsc_axi_router_cmd_rr #(
  parameter int SOURCES  = 1,
  parameter int SOURCESB = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SOURCES-1:0]  eligible,
  input  logic                advance,
  output logic [SOURCES-1:0]  grant_onehot,
  output logic [SOURCESB-1:0] grant_bin,
  output logic [SOURCESB-1:0] ptr
);

  always_comb begin
    logic found;
    int   idx;
    found        = 1'b0;
    idx          = 0;
    grant_onehot = '0;
    grant_bin    = '0;
    for (int i = 1; i <= SOURCES; i++) begin
      idx = (int'(ptr) + i) % SOURCES;
      if (!found && eligible[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_bin         = SOURCESB'(idx);
      end
    end
  end

  // Reset to the last source so source 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst)          ptr <= SOURCESB'(SOURCES-1);
    else if (advance) ptr <= grant_bin;
  end

endmodule

// File: rtl/dlsc_axi_router_cmd_arbiter.sv
// Address decode, eligibility and registered command issue for one channel.
// DLSC_AXI_ROUTER_CMD_DECERR_EN: unmapped requests produce decerr_push instead of routing to the last sink.
module dlsc_axi_router_cmd_arbiter
  import dlsc_axi_router_pkg::*;
#(
  parameter int ADDR     = 32,
  parameter int SOURCES  = 1,
  parameter int SOURCESB = 1,
  parameter int SINKS    = 1,
  parameter int SINKSB   = 1,
  parameter logic [SINKS*ADDR-1:0] SINK_BASE = '0,
  parameter logic [SINKS*ADDR-1:0] SINK_MASK = '0
) (
  input logic clk,
  input logic rst,
  dlsc_axi_router_cmd_arbiter_if.slave bus
);

`ifdef DLSC_AXI_ROUTER_CMD_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  logic [SOURCES-1:0][SINKS-1:0] route;
  logic [SOURCES-1:0]  miss, src_busy, elig, grant;
  logic [SINKS-1:0]    sink_busy, g_route;
  logic                g_miss, g_cmd, g_err;
  logic [SOURCESB-1:0] g_bin, rr_ptr_unused;

  logic                push_q, derr_q;
  logic [SOURCES-1:0]  src_oh_q;
  logic [SINKS-1:0]    sink_oh_q;
  logic [SOURCESB-1:0] src_q, derr_src_q;
  logic [SINKSB-1:0]   sink_q;

  // Lowest matching region wins; a miss falls to the last sink unless decerr is enabled.
  always_comb begin
    route = '0;
    miss  = '1;
    for (int j = 0; j < SOURCES; j++) begin
      for (int k = 0; k < SINKS; k++) begin
        if (miss[j] && region_match(MAXW'(bus.in_addr[j*ADDR+:ADDR]),
                                    MAXW'(SINK_BASE[k*ADDR+:ADDR]),
                                    MAXW'(SINK_MASK[k*ADDR+:ADDR]))) begin
          route[j][k] = 1'b1;
          miss[j]     = 1'b0;
        end
      end
      if (miss[j] && !DECERR_EN) route[j][SINKS-1] = 1'b1;
    end
  end

  // The command in flight counts as full: the channel's flags lag a cycle.
  assign src_busy  = bus.cmd_full_source | (src_oh_q & {SOURCES{push_q}});
  assign sink_busy = bus.cmd_full_sink   | (sink_oh_q & {SINKS{push_q}});

  always_comb begin
    elig = '0;
    for (int j = 0; j < SOURCES; j++)
      elig[j] = bus.in_valid[j] && !rst &&
                ((DECERR_EN && miss[j]) || (!src_busy[j] && !(|(route[j] & sink_busy))));
  end

  dlsc_axi_router_cmd_rr #(.SOURCES(SOURCES), .SOURCESB(SOURCESB)) u_rr (
    .clk          (clk),
    .rst          (rst),
    .eligible     (elig),
    .advance      (|grant),
    .grant_onehot (grant),
    .grant_bin    (g_bin),
    .ptr          (rr_ptr_unused)
  );

  always_comb begin
    g_route = '0;
    g_miss  = 1'b0;
    for (int j = 0; j < SOURCES; j++)
      if (grant[j]) begin
        g_route = g_route | route[j];
        g_miss  = g_miss | miss[j];
      end
  end

  assign g_err = (|grant) && DECERR_EN && g_miss;
  assign g_cmd = (|grant) && !g_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      push_q     <= 1'b0;
      derr_q     <= 1'b0;
      src_oh_q   <= '0;
      sink_oh_q  <= '0;
      src_q      <= '0;
      sink_q     <= '0;
      derr_src_q <= '0;
    end else begin
      push_q <= g_cmd;
      derr_q <= g_err;
      if (g_cmd) begin
        src_oh_q  <= grant;
        sink_oh_q <= g_route;
        src_q     <= g_bin;
        sink_q    <= SINKSB'(onehot2bin(MAXW'(g_route)));
      end
      if (g_err) derr_src_q <= g_bin;
    end
  end

  assign bus.in_ready          = grant;
  assign bus.cmd_push          = push_q;
  assign bus.cmd_source_onehot = src_oh_q;
  assign bus.cmd_sink_onehot   = sink_oh_q;
  assign bus.cmd_source        = src_q;
  assign bus.cmd_sink          = sink_q;
  assign bus.decerr_push       = derr_q;
  assign bus.decerr_source     = derr_src_q;

endmodule
